// File: rtl/rf_scoreboard.sv
// rtl/rf_scoreboard.sv - register-hazard scoreboard beside the RV32I register file
//
// Tracks outstanding writes per architectural register x1..x31 with a small
// saturating-by-construction counter each. Issue is held back while a used
// source operand still has a pending write (RAW) or while the destination's
// counter is already at its maximum (WAW depth limit). With BYPASS_EN=1 a
// writeback in the current cycle is treated as already complete, matching the
// register file's bypass behaviour.
//
// Ports:
//   i_clk, i_rst          clock (rising edge), asynchronous active-high reset
//   i_issue_valid         instruction presented for issue
//   i_issue_rs1/_used     source 1 address and whether it is read
//   i_issue_rs2/_used     source 2 address and whether it is read
//   i_issue_rd_wen/_rd    whether rd is written, and its address
//   o_issue_ready         issue allowed (independent of i_issue_valid)
//   i_wb_valid, i_wb_rd   a register-file write completes this cycle
//   o_busy                at least one counter is nonzero (registered state)
//   o_err                 sticky: writeback to a register with nothing pending

module rf_scoreboard #(
  parameter bit BYPASS_EN = 1'b0,
  parameter int CNT_W     = 2
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_issue_valid,
  input  logic [4:0] i_issue_rs1,
  input  logic       i_issue_rs1_used,
  input  logic [4:0] i_issue_rs2,
  input  logic       i_issue_rs2_used,
  input  logic       i_issue_rd_wen,
  input  logic [4:0] i_issue_rd,
  output logic       o_issue_ready,
  input  logic       i_wb_valid,
  input  logic [4:0] i_wb_rd,
  output logic       o_busy,
  output logic       o_err
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  // Per-register outstanding-write counters; x0 has none.
  logic [CNT_W-1:0] cnt [1:31];

  // Counter view indexed 0..31 with x0 tied to zero so address lookups need
  // no special case for register 0.
  logic [CNT_W-1:0] cnt_tbl [0:31];

  // Effective count after discounting a same-cycle writeback (bypass only).
  logic [CNT_W-1:0] eff [0:31];

  logic        raw1;
  logic        raw2;
  logic        waw_full;
  logic        fire;
  logic [31:1] inc_vec;
  logic [31:1] dec_vec;
  logic        underflow;

  always_comb begin
    cnt_tbl[0] = '0;
    for (int r = 1; r < 32; r++) begin
      cnt_tbl[r] = cnt[r];
    end
  end

  always_comb begin
    for (int r = 0; r < 32; r++) begin
      eff[r] = cnt_tbl[r];
      if (BYPASS_EN && i_wb_valid && (i_wb_rd == 5'(r)) && (cnt_tbl[r] != '0)) begin
        eff[r] = cnt_tbl[r] - CNT_ONE;
      end
    end
  end

  // Hazard checks. x0 reads and writes never stall.
  always_comb begin
    raw1     = i_issue_rs1_used && (i_issue_rs1 != 5'd0) && (eff[i_issue_rs1] != '0);
    raw2     = i_issue_rs2_used && (i_issue_rs2 != 5'd0) && (eff[i_issue_rs2] != '0);
    waw_full = i_issue_rd_wen && (i_issue_rd != 5'd0) && (eff[i_issue_rd] == CNT_MAX);
  end

  assign o_issue_ready = !(raw1 || raw2 || waw_full);
  assign fire          = i_issue_valid && o_issue_ready;

  // A writeback to a register with nothing pending is ignored for the count
  // and flagged instead, so counters can never wrap below zero.
  always_comb begin
    for (int r = 1; r < 32; r++) begin
      inc_vec[r] = fire && i_issue_rd_wen && (i_issue_rd == 5'(r));
      dec_vec[r] = i_wb_valid && (i_wb_rd == 5'(r)) && (cnt[r] != '0);
    end
  end

  assign underflow = i_wb_valid && (i_wb_rd != 5'd0) && (cnt_tbl[i_wb_rd] == '0);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int r = 1; r < 32; r++) begin
        cnt[r] <= '0;
      end
      o_err <= 1'b0;
    end else begin
      for (int r = 1; r < 32; r++) begin
        // Simultaneous inc and dec leave the count unchanged.
        if (inc_vec[r] && !dec_vec[r]) begin
          cnt[r] <= cnt[r] + CNT_ONE;
        end else if (dec_vec[r] && !inc_vec[r]) begin
          cnt[r] <= cnt[r] - CNT_ONE;
        end
      end
      if (underflow) begin
        o_err <= 1'b1;
      end
    end
  end

  always_comb begin
    o_busy = 1'b0;
    for (int r = 1; r < 32; r++) begin
      o_busy = o_busy | (cnt[r] != '0);
    end
  end

endmodule
